branch_sched: RTL and testbench

- Shares one branch-resolution datapath (condition compare plus target adder, instantiated internally) among NUM_REQ branch reservation-station entries.
- Arbitration is round-robin, one issue per cycle.
- Each resolved branch is registered into a single result stage with valid/ready backpressure, and the block flags mispredictions.
- After a misprediction, a squash FSM blocks further issue for a fixed window while the front end redirects.

---
 rtl/branch_sched_if.sv | 38 +++
 rtl/branch_sched.sv | 151 +++++++++++++++
 tb/tb_branch_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sched_if.sv
// rtl/branch_sched_if.sv - request/result bundle for the shared branch resolver
interface branch_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*32-1:0]    req_rs1;
  logic [NUM_REQ*32-1:0]    req_rs2;
  logic [NUM_REQ*3-1:0]     req_func;
  logic [NUM_REQ*32-1:0]    req_pc;
  logic [NUM_REQ*32-1:0]    req_offset;
  logic [NUM_REQ-1:0]       req_pred_taken;
  logic [NUM_REQ*32-1:0]    req_pred_target;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       grant;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_take;
  logic [31:0]              res_target;
  logic [31:0]              res_link;
  logic                     res_mispredict;
  logic [TAG_W-1:0]         res_tag;
  logic                     squashing;

  modport master (
    output req_valid, req_rs1, req_rs2, req_func, req_pc, req_offset,
           req_pred_taken, req_pred_target, req_tag, res_ready,
    input  grant, res_valid, res_take, res_target, res_link, res_mispredict,
           res_tag, squashing
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_func, req_pc, req_offset,
           req_pred_taken, req_pred_target, req_tag, res_ready,
    output grant, res_valid, res_take, res_target, res_link, res_mispredict,
           res_tag, squashing
  );
endinterface

// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - round-robin shared branch resolver with result stage and squash window
module branch_sched #(
  parameter int NUM_REQ       = 4,
  parameter int TAG_W         = 5,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  branch_sched_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);

  localparam logic [2:0] F_EQ   = 3'd0;
  localparam logic [2:0] F_NE   = 3'd1;
  localparam logic [2:0] F_LT   = 3'd2;
  localparam logic [2:0] F_GE   = 3'd3;
  localparam logic [2:0] F_LTU  = 3'd4;
  localparam logic [2:0] F_GEU  = 3'd5;
  localparam logic [2:0] F_JAL  = 3'd6;
  localparam logic [2:0] F_JALR = 3'd7;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic               rv_q;
  logic               take_q;
  logic [31:0]        target_q;
  logic [31:0]        link_q;
  logic               mis_q;
  logic [TAG_W-1:0]   tag_q;

  logic               issue_ok;
  logic               found;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   cidx;
  int                 cand;
  logic [NUM_REQ-1:0] gnt;

  // A mispredicting result blocks issue in the very cycle it is accepted.
  always_comb begin
    issue_ok = (state == RUN) && (!rv_q || (bus.res_ready && !mis_q));
    found    = 1'b0;
    gidx     = '0;
    cidx     = '0;
    cand     = 0;
    gnt      = '0;
    if (issue_ok) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        cidx = PTR_W'(cand);
        if (!found && bus.req_valid[cidx]) begin
          found = 1'b1;
          gidx  = cidx;
        end
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  logic [31:0]      rs1, rs2, pc, off, ptgt, link, jalr_sum, tgt;
  logic [2:0]       func;
  logic             ptk, eq, lt, ltu, take, mis;
  logic [TAG_W-1:0] tag;

  assign rs1  = bus.req_rs1[32*gidx +: 32];
  assign rs2  = bus.req_rs2[32*gidx +: 32];
  assign pc   = bus.req_pc[32*gidx +: 32];
  assign off  = bus.req_offset[32*gidx +: 32];
  assign ptgt = bus.req_pred_target[32*gidx +: 32];
  assign func = bus.req_func[3*gidx +: 3];
  assign ptk  = bus.req_pred_taken[gidx];
  assign tag  = bus.req_tag[TAG_W*gidx +: TAG_W];

  always_comb begin
    eq       = (rs1 == rs2);
    lt       = ($signed(rs1) < $signed(rs2));
    ltu      = (rs1 < rs2);
    link     = pc + 32'd4;
    jalr_sum = rs1 + off;
    case (func)
      F_EQ:         take = eq;
      F_NE:         take = !eq;
      F_LT:         take = lt;
      F_GE:         take = !lt;
      F_LTU:        take = ltu;
      F_GEU:        take = !ltu;
      F_JAL, F_JALR: take = 1'b1;
      default:      take = 1'b0;
    endcase
    if (func == F_JALR) tgt = {jalr_sum[31:1], 1'b0};
    else if (take)      tgt = pc + off;
    else                tgt = link;
    mis = (take != ptk) || (take && (tgt != ptgt));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      ptr      <= '0;
      rv_q     <= 1'b0;
      take_q   <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
      mis_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      if (found) begin
        rv_q     <= 1'b1;
        take_q   <= take;
        target_q <= tgt;
        link_q   <= link;
        mis_q    <= mis;
        tag_q    <= tag;
        ptr      <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end else if (bus.res_ready) begin
        rv_q <= 1'b0;
      end

      case (state)
        RUN: begin
          if (rv_q && mis_q && bus.res_ready) begin
            state <= SQUASH;
            cnt   <= CNT_W'(SQUASH_CYCLES);
          end
        end
        SQUASH: begin
          if (cnt == CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.grant          = gnt;
  assign bus.res_valid      = rv_q;
  assign bus.res_take       = take_q;
  assign bus.res_target     = target_q;
  assign bus.res_link       = link_q;
  assign bus.res_mispredict = mis_q;
  assign bus.res_tag        = tag_q;
  assign bus.squashing      = (state == SQUASH);
endmodule

// File: tb/tb_branch_sched.sv
// tb/tb_branch_sched.sv - directed and randomized bench for branch_sched
module tb_branch_sched;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int SQ = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_sched_if #(.NUM_REQ(N), .TAG_W(TW)) bus();
  branch_sched #(.NUM_REQ(N), .TAG_W(TW), .SQUASH_CYCLES(SQ)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: pointer, pending result (0 or 1 entries) and squash cycles left.
  int              m_ptr, m_sq, last_g;
  bit              m_rv, m_take, m_mis;
  logic [31:0]     m_target, m_link;
  logic [TW-1:0]   m_tag;

  function automatic void resolve(input logic [2:0] f, input logic [31:0] a, b, pc, off,
                                  output bit t, output logic [31:0] tg);
    case (f)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd2: t = ($signed(a) < $signed(b));
      3'd3: t = !($signed(a) < $signed(b));
      3'd4: t = (a < b);
      3'd5: t = !(a < b);
      default: t = 1'b1;
    endcase
    if (f == 3'd7) tg = (a + off) & 32'hFFFF_FFFE;
    else           tg = t ? pc + off : pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sq = 0; m_rv = 0; last_g = -1;
    m_take = 0; m_mis = 0; m_target = '0; m_link = '0; m_tag = '0;
  endtask

  function automatic int model_grant();
    if (m_sq > 0) return -1;
    if (m_rv && !bus.res_ready) return -1;
    if (m_rv && m_mis) return -1;
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_clock();
    int g;
    bit acc, t;
    logic [31:0] tg, pc;
    if (reset) begin
      model_reset();
      return;
    end
    g   = model_grant();
    acc = (m_sq == 0) && m_rv && m_mis && bus.res_ready;
    if (m_sq > 0) m_sq--;
    else if (acc) m_sq = SQ;
    if (g >= 0) begin
      pc = bus.req_pc[32*g +: 32];
      resolve(bus.req_func[3*g +: 3], bus.req_rs1[32*g +: 32], bus.req_rs2[32*g +: 32],
              pc, bus.req_offset[32*g +: 32], t, tg);
      m_rv = 1; m_take = t; m_target = tg; m_link = pc + 32'd4;
      m_mis = (t != bus.req_pred_taken[g]) || (t && tg != bus.req_pred_target[32*g +: 32]);
      m_tag = bus.req_tag[TW*g +: TW];
      m_ptr = (g + 1) % N;
    end else if (bus.res_ready) begin
      m_rv = 0;
    end
    last_g = g;
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f, input logic [31:0] a, b, pc, off,
                         input bit pt, input logic [31:0] ptg, input logic [TW-1:0] tag);
    bus.req_func[3*i +: 3]         = f;
    bus.req_rs1[32*i +: 32]        = a;
    bus.req_rs2[32*i +: 32]        = b;
    bus.req_pc[32*i +: 32]         = pc;
    bus.req_offset[32*i +: 32]     = off;
    bus.req_pred_taken[i]          = pt;
    bus.req_pred_target[32*i +: 32] = ptg;
    bus.req_tag[TW*i +: TW]        = tag;
  endtask

  task automatic clear_all();
    bus.req_valid = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_func = '0;
    bus.req_pc = '0; bus.req_offset = '0; bus.req_pred_taken = '0;
    bus.req_pred_target = '0; bus.req_tag = '0; bus.res_ready = 1'b1;
  endtask

  task automatic set_all_benign();
    for (int i = 0; i < N; i++)
      set_req(i, 3'd0, 32'd1, 32'd2, 32'h200 + 32'(16*i), 32'd8, 1'b0, 32'd0, TW'(i));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_all();
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
    total++; if (bus.squashing !== 1'b0) begin bad++; $display("FAIL reset_squashing: got %b want 0", bus.squashing); end
    total++;
    if ({bus.res_take, bus.res_target, bus.res_link, bus.res_mispredict, bus.res_tag} !== '0) begin
      bad++; $display("FAIL reset_res_data: got target=%h link=%h tag=%h want all 0", bus.res_target, bus.res_link, bus.res_tag);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_rr_all();
    logic [N-1:0] exp;
    set_all_benign();
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      exp = N'(1) << (k % N);
      total++; if (bus.grant !== exp) begin bad++; $display("FAIL rr_all_grant%0d: got %b want %b", k, bus.grant, exp); end
      tick();
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_rr_pair();
    bus.req_valid = 4'b0101;
    @(negedge clock);
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL rr_pair_grant: got %b want 0100", bus.grant); end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_beq();
    set_req(0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 5'd3);
    bus.req_valid = 4'b0001;
    @(negedge clock);
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL beq_grant: got %b want 0001", bus.grant); end
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL beq_valid: got %b want 1", bus.res_valid); end
    total++;
    if ({bus.res_take, bus.res_target, bus.res_link, bus.res_mispredict, bus.res_tag} !==
        {1'b1, 32'h120, 32'h104, 1'b0, 5'd3}) begin
      bad++; $display("FAIL beq_data: got take=%b tgt=%h link=%h mis=%b tag=%0d want 1 120 104 0 3",
                      bus.res_take, bus.res_target, bus.res_link, bus.res_mispredict, bus.res_tag);
    end
    tick();
  endtask

  task automatic test_funcs();
    logic [2:0]  fs[3]   = '{3'd2, 3'd4, 3'd7};
    logic [31:0] a[3]    = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1001};
    logic [31:0] pcs[3]  = '{32'h300, 32'h300, 32'h400};
    logic [31:0] offs[3] = '{32'h40, 32'h40, 32'd4};
    bit          pts[3]  = '{1'b1, 1'b0, 1'b1};
    logic [31:0] ptg[3]  = '{32'h340, 32'h0, 32'h1004};
    bit          et[3]   = '{1'b1, 1'b0, 1'b1};
    logic [31:0] etg[3]  = '{32'h340, 32'h304, 32'h1004};
    for (int c = 0; c < 3; c++) begin
      set_req(0, fs[c], a[c], 32'd1, pcs[c], offs[c], pts[c], ptg[c], TW'(c));
      bus.req_valid = 4'b0001;
      @(negedge clock);
      total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL func%0d_grant: got %b want 0001", c, bus.grant); end
      tick();
      bus.req_valid = '0;
      @(negedge clock);
      total++;
      if ({bus.res_take, bus.res_target, bus.res_mispredict} !== {et[c], etg[c], 1'b0}) begin
        bad++; $display("FAIL func%0d_result: got take=%b tgt=%h mis=%b want take=%b tgt=%h mis=0",
                        c, bus.res_take, bus.res_target, bus.res_mispredict, et[c], etg[c]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int r, a;
    r = m_ptr;
    a = (r + 2) % N;
    set_req(r, 3'd0, 32'd7, 32'd7, 32'h500, 32'h10, 1'b1, 32'h510, 5'd9);
    bus.req_valid = N'(1) << r;
    bus.res_ready = 1'b0;
    @(negedge clock);
    total++; if (bus.grant !== N'(1) << r) begin bad++; $display("FAIL bp_first_grant: got %b want %b", bus.grant, N'(1) << r); end
    tick();
    set_req(a, 3'd0, 32'd1, 32'd2, 32'h600, 32'h10, 1'b0, 32'd0, 5'd10);
    set_req(r, 3'd0, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0, 32'd0, 5'd11);
    bus.req_valid = (N'(1) << r) | (N'(1) << a);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++; if (bus.grant !== '0) begin bad++; $display("FAIL bp_stall_grant%0d: got %b want 0", k, bus.grant); end
      total++;
      if ({bus.res_valid, bus.res_target, bus.res_tag} !== {1'b1, 32'h510, 5'd9}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b tgt=%h tag=%0d want 1 510 9", k, bus.res_valid, bus.res_target, bus.res_tag);
      end
      tick();
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    total++; if (bus.grant !== N'(1) << a) begin bad++; $display("FAIL bp_release_grant: got %b want %b", bus.grant, N'(1) << a); end
    tick();
    bus.req_valid = '0;
    @(negedge clock);
    total++;
    if ({bus.res_valid, bus.res_target, bus.res_tag} !== {1'b1, 32'h604, 5'd10}) begin
      bad++; $display("FAIL bp_next_result: got v=%b tgt=%h tag=%0d want 1 604 10", bus.res_valid, bus.res_target, bus.res_tag);
    end
    tick();
  endtask

  task automatic test_mispredict();
    int r, b;
    r = m_ptr;
    b = (r + 1) % N;
    set_req(r, 3'd1, 32'd1, 32'd2, 32'h800, 32'h40, 1'b0, 32'h804, 5'd11);
    set_req(b, 3'd0, 32'd3, 32'd3, 32'h900, 32'h8, 1'b1, 32'h908, 5'd12);
    bus.req_valid = N'(1) << r;
    bus.res_ready = 1'b1;
    @(negedge clock);
    total++; if (bus.grant !== N'(1) << r) begin bad++; $display("FAIL mp_grant: got %b want %b", bus.grant, N'(1) << r); end
    tick();
    bus.req_valid = N'(1) << b;
    @(negedge clock);
    total++;
    if ({bus.res_take, bus.res_target, bus.res_mispredict} !== {1'b1, 32'h840, 1'b1}) begin
      bad++; $display("FAIL mp_result: got take=%b tgt=%h mis=%b want 1 840 1", bus.res_take, bus.res_target, bus.res_mispredict);
    end
    total++; if (bus.grant !== '0) begin bad++; $display("FAIL mp_accept_grant: got %b want 0", bus.grant); end
    tick();
    for (int k = 0; k < SQ; k++) begin
      @(negedge clock);
      total++;
      if ({bus.squashing, bus.grant} !== {1'b1, N'(0)}) begin
        bad++; $display("FAIL mp_squash%0d: got sq=%b grant=%b want sq=1 grant=0", k, bus.squashing, bus.grant);
      end
      tick();
    end
    @(negedge clock);
    total++;
    if ({bus.squashing, bus.grant} !== {1'b0, N'(1) << b}) begin
      bad++; $display("FAIL mp_resume: got sq=%b grant=%b want sq=0 grant=%b", bus.squashing, bus.grant, N'(1) << b);
    end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    int r;
    r = m_ptr;
    set_req(r, 3'd0, 32'd0, 32'd0, 32'hA00, 32'd4, 1'b1, 32'hA04, 5'd13);
    bus.req_valid = N'(1) << r;
    bus.res_ready = 1'b0;
    tick();
    bus.req_valid = '0;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL ar_pending_valid: got %b want 0", bus.res_valid); end
    model_reset();
    tick();
    reset = 1'b0;
    bus.res_ready = 1'b1;
    set_req(0, 3'd1, 32'd1, 32'd2, 32'hB00, 32'h10, 1'b0, 32'hB04, 5'd14);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clock);
    total++; if (bus.squashing !== 1'b1) begin bad++; $display("FAIL ar_in_squash: got %b want 1", bus.squashing); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.squashing, bus.res_valid} !== 2'b00) begin
      bad++; $display("FAIL ar_squash_reset: got sq=%b v=%b want 0 0", bus.squashing, bus.res_valid);
    end
    model_reset();
    tick();
    reset = 1'b0;
    set_all_benign();
    bus.req_valid = '1;
    @(negedge clock);
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL ar_first_grant: got %b want 0001", bus.grant); end
    tick();
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int g;
    bit t;
    logic [2:0]  f;
    logic [31:0] a, b, pc, off, tg, rnd;
    logic [N-1:0] eg;
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || last_g == i) begin
          if ($urandom_range(0, 1) == 1) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            rnd = $urandom;
            off = {{20{rnd[11]}}, rnd[11:0]};
            resolve(f, a, b, pc, off, t, tg);
            if ($urandom_range(0, 4) == 0) t = !t;
            if ($urandom_range(0, 4) == 0) tg = $urandom;
            set_req(i, f, a, b, pc, off, t, tg, TW'($urandom));
            bus.req_valid[i] = 1'b1;
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      bus.res_ready = ($urandom_range(0, 9) < 7);
      @(negedge clock);
      g  = model_grant();
      eg = (g >= 0) ? (N'(1) << g) : '0;
      total++; if (bus.grant !== eg) begin bad++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, bus.grant, eg); end
      total++; if (bus.res_valid !== m_rv) begin bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, bus.res_valid, m_rv); end
      total++; if (bus.squashing !== (m_sq > 0)) begin bad++; $display("FAIL rnd_squash c=%0d: got %b want %b", c, bus.squashing, m_sq > 0); end
      if (m_rv) begin
        total++;
        if ({bus.res_take, bus.res_target, bus.res_link, bus.res_mispredict, bus.res_tag} !==
            {m_take, m_target, m_link, m_mis, m_tag}) begin
          bad++; $display("FAIL rnd_data c=%0d: got %b %h %h %b %h want %b %h %h %b %h", c,
                          bus.res_take, bus.res_target, bus.res_link, bus.res_mispredict, bus.res_tag,
                          m_take, m_target, m_link, m_mis, m_tag);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_rr_pair();
    test_beq();
    test_funcs();
    test_backpressure();
    test_mispredict();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
